// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader path: loader FSM
// state encoding, instruction word geometry and the default terminator.
package mips_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    // HALT encoding; a load ends once this word has been written.
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: shifts incoming bytes into a word register so the
// first byte of a group lands in the most significant byte. word_valid is a
// combinational flag that is high in the cycle whose byte completes a word;
// word_next is the complete word in that same cycle.
module byte_packer
    import mips_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic [DATA_W-1:0] word_next,
    output logic              word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [DATA_W-1:0] shift_q;
    logic [1:0]        byte_cnt_q;
    logic              take;

    assign take       = accept && byte_valid;
    assign word_next  = {shift_q[DATA_W-9:0], byte_data};
    assign word_valid = take && (byte_cnt_q == LAST_BYTE);

    // Shift register and byte counter; clear wins over a byte in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (clear) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (take) begin
            shift_q    <= word_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader. Packs the debug UART byte stream into 32-bit
// big-endian words and writes them to consecutive word addresses starting at
// a byte-addressed base. A load ends after the terminator word is written or
// after the last memory address is written (o_full).
//
// Handshake: there is no backpressure. i_rx_valid is a one-cycle strobe and
// i_rx_data is only meaningful while it is high; bytes are accepted in RECV
// and in WRITE (unless WRITE ends the load) and dropped everywhere else.
// o_mem_we is high for exactly one cycle per word and is the only qualifier
// of o_mem_addr / o_mem_data, which otherwise hold their last values.
module instr_mem_loader
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] END_WORD = HALT_WORD
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [ADDR_W+1:0]   i_base_addr,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_mem_ce,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_full,
    output logic [ADDR_W:0]     o_word_count,
    output loader_state_t       o_state
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   WC_MAX    = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_ok;
    logic              exit_done;
    logic              pack_accept;
    logic              pack_clear;
    logic [DATA_W-1:0] word_next;
    logic              word_valid;
    logic [1:0]        unused_base_lsb;

    // Byte-offset bits of the base address are irrelevant to word addressing.
    assign unused_base_lsb = i_base_addr[1:0];

    assign o_state = state_q;

    // A start is honoured only between loads.
    assign start_ok = i_start && ((state_q == IDLE) || (state_q == DONE));

    // The word being written this cycle ends the load if it is the
    // terminator or if it sits at the last memory address.
    assign exit_done = (state_q == WRITE) &&
                       ((o_mem_data == END_WORD) || (addr_q == ADDR_LAST));

    // A byte arriving in WRITE seeds the next word, unless the load ends.
    assign pack_accept = (state_q == RECV) || ((state_q == WRITE) && !exit_done);
    assign pack_clear  = start_ok || exit_done;

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (pack_clear),
        .accept     (pack_accept),
        .byte_data  (i_rx_data),
        .byte_valid (i_rx_valid),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    // Loader FSM with registered memory-port and status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            o_mem_ce     <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_full       <= 1'b0;
            o_word_count <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q      <= RECV;
                        addr_q       <= i_base_addr[ADDR_W+1:2];
                        o_word_count <= '0;
                        o_full       <= 1'b0;
                        o_done       <= 1'b0;
                        o_mem_ce     <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                RECV: begin
                    if (word_valid) begin
                        state_q    <= WRITE;
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= addr_q;
                        o_mem_data <= word_next;
                    end
                end
                WRITE: begin
                    o_mem_we <= 1'b0;
                    if (o_word_count != WC_MAX) begin
                        o_word_count <= o_word_count + 1'b1;
                    end
                    if (exit_done) begin
                        state_q  <= DONE;
                        o_done   <= 1'b1;
                        o_full   <= (o_mem_data != END_WORD);
                        o_mem_ce <= 1'b0;
                        o_busy   <= 1'b0;
                    end else begin
                        state_q <= RECV;
                        addr_q  <= addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a default-sized instance (ADDR_W=8) and a tiny
// instance (ADDR_W=2) share the same stimulus; each is compared every cycle
// against a transaction-level model of the loader.
module tb_instr_mem_loader;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus signals ----------------
  logic       i_start;
  logic [9:0] i_base_addr;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;

  // big instance outputs
  logic        b_ce, b_we, b_busy, b_done, b_full;
  logic [7:0]  b_addr;
  logic [31:0] b_data;
  logic [8:0]  b_cnt;
  logic [1:0]  b_state;

  // small instance outputs
  logic        s_ce, s_we, s_busy, s_done, s_full;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  logic [2:0]  s_cnt;
  logic [1:0]  s_state;

  instr_mem_loader #(.ADDR_W(8)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_mem_ce     (b_ce),
    .o_mem_we     (b_we),
    .o_mem_addr   (b_addr),
    .o_mem_data   (b_data),
    .o_busy       (b_busy),
    .o_done       (b_done),
    .o_full       (b_full),
    .o_word_count (b_cnt),
    .o_state      (b_state)
  );

  instr_mem_loader #(.ADDR_W(2)) u_small (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr[3:0]),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_mem_ce     (s_ce),
    .o_mem_we     (s_we),
    .o_mem_addr   (s_addr),
    .o_mem_data   (s_data),
    .o_busy       (s_busy),
    .o_done       (s_done),
    .o_full       (s_full),
    .o_word_count (s_cnt),
    .o_state      (s_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance k (0 = ADDR_W 8, 1 = ADDR_W 2): a load is either active or
  // not; while active, bytes accumulate arithmetically into a word, and a
  // complete word produces one write cycle.
  bit          m_active[2];
  bit          m_wr[2];
  bit          m_done[2];
  bit          m_full[2];
  int          m_addr[2];
  int          m_count[2];
  int          m_nb[2];
  int          m_last_addr[2];
  logic [31:0] m_acc[2];
  logic [31:0] m_last_data[2];

  logic [39:0] exp_q[$];   // expected writes of the big instance {addr, data}
  logic [31:0] dut_mem[256];
  int          b_last_wr_addr;
  int          b_wr_cnt;
  int          s_last_wr_addr;
  int          s_wr_cnt;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_wr[k] = 0; m_done[k] = 0; m_full[k] = 0;
      m_addr[k] = 0; m_count[k] = 0; m_nb[k] = 0; m_last_addr[k] = 0;
      m_acc[k] = '0; m_last_data[k] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int k);
    int aw;
    int depth;
    int base_word;
    aw        = (k == 0) ? 8 : 2;
    depth     = 1 << aw;
    base_word = (k == 0) ? int'(i_base_addr) / 4 : int'(i_base_addr[3:0]) / 4;
    if (!m_active[k]) begin
      if (i_start) begin
        m_active[k] = 1; m_done[k] = 0; m_full[k] = 0; m_count[k] = 0;
        m_addr[k] = base_word; m_nb[k] = 0; m_acc[k] = '0;
      end
    end else if (m_wr[k]) begin
      m_wr[k] = 0;
      if (m_count[k] < depth) m_count[k]++;
      if (m_last_data[k] == 32'hFFFF_FFFF || m_last_addr[k] == depth - 1) begin
        m_active[k] = 0;
        m_done[k]   = 1;
        m_full[k]   = (m_last_data[k] != 32'hFFFF_FFFF);
        m_nb[k]     = 0;
      end else begin
        m_addr[k]++;
        if (i_rx_valid) begin
          m_acc[k] = 32'(i_rx_data);
          m_nb[k]  = 1;
        end
      end
    end else if (i_rx_valid) begin
      m_acc[k] = m_acc[k] * 256 + 32'(i_rx_data);
      m_nb[k]++;
      if (m_nb[k] == 4) begin
        m_wr[k]        = 1;
        m_last_addr[k] = m_addr[k];
        m_last_data[k] = m_acc[k];
        m_nb[k]        = 0;
        if (k == 0) exp_q.push_back({8'(m_addr[k]), m_acc[k]});
      end
    end
  endtask

  function automatic logic [31:0] exp_state(input int k);
    if (!m_active[k]) return m_done[k] ? 32'd3 : 32'd0;
    return m_wr[k] ? 32'd2 : 32'd1;
  endfunction

  // ---------------- scoreboard / compare ----------------
  task automatic compare_big();
    logic [39:0] e;
    check("big_we",    32'(b_we),   32'(m_wr[0]));
    check("big_ce",    32'(b_ce),   32'(m_active[0]));
    check("big_busy",  32'(b_busy), 32'(m_active[0]));
    check("big_done",  32'(b_done), 32'(m_done[0]));
    check("big_full",  32'(b_full), 32'(m_full[0]));
    check("big_count", 32'(b_cnt),  32'(m_count[0]));
    check("big_addr",  32'(b_addr), 32'(m_last_addr[0]));
    check("big_data",  b_data,      m_last_data[0]);
    check("big_state", 32'(b_state), exp_state(0));
    if (b_we) begin
      dut_mem[b_addr] = b_data;
      b_last_wr_addr  = int'(b_addr);
      b_wr_cnt++;
      if (exp_q.size() == 0) begin
        check("big_unexpected_write", 32'(b_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("big_sb_addr", 32'(b_addr), 32'(e[39:32]));
        check("big_sb_data", b_data, e[31:0]);
      end
    end
  endtask

  task automatic compare_small();
    check("small_we",    32'(s_we),   32'(m_wr[1]));
    check("small_ce",    32'(s_ce),   32'(m_active[1]));
    check("small_busy",  32'(s_busy), 32'(m_active[1]));
    check("small_done",  32'(s_done), 32'(m_done[1]));
    check("small_full",  32'(s_full), 32'(m_full[1]));
    check("small_count", 32'(s_cnt),  32'(m_count[1]));
    check("small_addr",  32'(s_addr), 32'(m_last_addr[1]));
    check("small_data",  s_data,      m_last_data[1]);
    check("small_state", 32'(s_state), exp_state(1));
    if (s_we) begin
      s_last_wr_addr = int'(s_addr);
      s_wr_cnt++;
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #2;
    compare_big();
    compare_small();
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_q[$];
  bit         rand_starts = 0;

  task automatic do_start(input logic [9:0] base);
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = base;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic send_q(input int max_gap);
    int gap;
    while (tx_q.size() > 0) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
      end
      @(negedge clk);
      i_rx_valid = 1'b1;
      i_rx_data  = tx_q.pop_front();
      if (rand_starts && $urandom_range(0, 7) == 0) begin
        i_start     = 1'b1;
        i_base_addr = 10'($urandom);
      end else begin
        i_start = 1'b0;
      end
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_start    = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!b_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_timeout", 32'(b_done), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] burst[8];
  int         b_snap, s_snap;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_rx_data = '0; i_rx_valid = 1'b0;
    b_last_wr_addr = -1; b_wr_cnt = 0; s_last_wr_addr = -1; s_wr_cnt = 0;
    for (int i = 0; i < 256; i++) dut_mem[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_done", 32'(b_done), 32'd0);
    check("reset_we",   32'(b_we),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three words ending with the terminator.
    do_start(10'h000);
    tx_q = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_q(2);
    wait_done(200);
    @(negedge clk);
    check("t1_mem0", dut_mem[0], 32'hAAAA_BBBB);
    check("t1_mem1", dut_mem[1], 32'hCCCC_DDDD);
    check("t1_mem2", dut_mem[2], 32'hFFFF_FFFF);
    check("t1_count", 32'(b_cnt), 32'd3);
    check("t1_model_count", 32'(m_count[0]), 32'd3);
    check("t1_full", 32'(b_full), 32'd0);
    check("t1_done", 32'(b_done), 32'd1);

    // Byte base 0x10 and 0x13 both map to word address 4.
    do_start(10'h010);
    tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    push_word(32'hFFFF_FFFF);
    send_q(1);
    wait_done(200);
    @(negedge clk);
    check("t2_mem4", dut_mem[4], 32'h1234_5678);
    do_start(10'h013);
    tx_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_q(0);
    repeat (2) @(negedge clk);
    check("t2_base13_addr", 32'(b_last_wr_addr), 32'd4);
    check("t2_base13_data", dut_mem[4], 32'h9ABC_DEF0);
    push_word(32'hFFFF_FFFF);
    send_q(0);
    wait_done(200);

    // Back-to-back bytes, including one in the WRITE cycle.
    do_start(10'h020);
    for (int i = 0; i < 8; i++) burst[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 8; i++) tx_q.push_back(burst[i]);
    send_q(0);
    repeat (2) @(negedge clk);
    check("t3_word0", dut_mem[8], {burst[0], burst[1], burst[2], burst[3]});
    check("t3_word1", dut_mem[9], {burst[4], burst[5], burst[6], burst[7]});
    check("t3_count", 32'(b_cnt), 32'd2);
    push_word(32'hFFFF_FFFF);
    send_q(0);
    wait_done(200);

    // Fill to the last address: small instance 0..3, big instance 252..255.
    do_start(10'h3F0);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom_range(0, 254)));
    send_q(1);
    wait_done(300);
    @(negedge clk);
    check("t4_small_full",  32'(s_full), 32'd1);
    check("t4_small_done",  32'(s_done), 32'd1);
    check("t4_small_count", 32'(s_cnt),  32'd4);
    check("t4_small_last",  32'(s_last_wr_addr), 32'd3);
    check("t4_big_full",    32'(b_full), 32'd1);
    check("t4_big_last",    32'(b_last_wr_addr), 32'd255);
    b_snap = b_wr_cnt;
    s_snap = s_wr_cnt;
    tx_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_q(0);
    repeat (3) @(negedge clk);
    check("t4_big_no_write",   32'(b_wr_cnt), 32'(b_snap));
    check("t4_small_no_write", 32'(s_wr_cnt), 32'(s_snap));

    // Reset asserted in the middle of a WRITE cycle.
    do_start(10'h040);
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_q(0);
    check("t5_in_write", 32'(b_we), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_we_async",   32'(b_we),   32'd0);
    check("t5_ce_async",   32'(b_ce),   32'd0);
    check("t5_busy_async", 32'(b_busy), 32'd0);
    check("t5_data_async", b_data,      32'd0);
    check("t5_addr_async", 32'(b_addr), 32'd0);
    check("t5_state_async", 32'(b_state), 32'd0);
    check("t5_small_we_async", 32'(s_we), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(10'h040);
    push_word(32'h1122_3344);
    push_word(32'hFFFF_FFFF);
    send_q(1);
    wait_done(200);
    @(negedge clk);
    check("t5_reload_mem16", dut_mem[16], 32'h1122_3344);
    check("t5_reload_count", 32'(b_cnt), 32'd2);

    // Stray bytes before start and a start pulse mid-load are ignored.
    apply_reset();
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_q(1);
    do_start(10'h080);
    tx_q = '{8'hCA, 8'hFE};
    send_q(0);
    do_start(10'h100);
    tx_q = '{8'hBA, 8'hBE};
    send_q(0);
    repeat (2) @(negedge clk);
    check("t6_addr", 32'(b_last_wr_addr), 32'd32);
    check("t6_data", dut_mem[32], 32'hCAFE_BABE);
    push_word(32'hFFFF_FFFF);
    send_q(0);
    wait_done(200);

    // Randomized loads with random gaps and stray start pulses.
    for (int n = 0; n < 8; n++) begin
      int nw;
      nw = $urandom_range(1, 4);
      rand_starts = 0;
      do_start(10'(($urandom_range(0, 250) << 2) | $urandom_range(0, 3)));
      rand_starts = 1;
      for (int w = 0; w < nw; w++) begin
        tx_q.push_back(8'($urandom_range(0, 254)));
        for (int j = 0; j < 3; j++) tx_q.push_back(8'($urandom));
      end
      push_word(32'hFFFF_FFFF);
      send_q(2);
      rand_starts = 0;
      wait_done(400);
      repeat (2) @(negedge clk);
    end

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction-memory interface. Receives a byte stream from the debug UART receiver, packs each group of four bytes into a 32-bit big-endian MIPS word, and writes it to the instruction memory. Memory writes use word addresses starting from a byte-addressed base; the byte-to-word conversion (>>2) happens here, so PC-style byte addresses never reach the memory port. Sits between uart_rx and the instruction memory write port; the debug unit starts it and monitors it.

Parameters:
ADDR_W, 8, memory word-address width (depth = 2**ADDR_W words)
DATA_W, 32, memory word width; fixed at 32, other values unsupported
END_WORD, 32'hFFFF_FFFF, terminator word; it is written to memory, then the load ends

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  1-cycle pulse; arms a load, honoured in IDLE or DONE only
i_base_addr  in  ADDR_W+2  byte address of first word; bits [1:0] ignored; sampled on accepted i_start
i_rx_data  in  8  received byte
i_rx_valid  in  1  1-cycle strobe; i_rx_data valid this cycle
o_mem_ce  out  1  memory clock enable; high in RECV and WRITE
o_mem_we  out  1  memory write enable; exactly one cycle per word
o_mem_addr  out  ADDR_W  word address
o_mem_data  out  32  word to write
o_busy  out  1  high in RECV and WRITE
o_done  out  1  high in DONE until the next accepted i_start or reset
o_full  out  1  load ended at the last address without END_WORD; cleared on accepted i_start
o_word_count  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; every output 0; byte counter and shift register cleared. Takes effect immediately mid-load, including during a WRITE cycle, so o_mem_we drops without waiting for a clock edge.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + i_start -> RECV:
  - word address <= i_base_addr[ADDR_W+1:2]
  - byte count, o_word_count, o_full, o_done cleared
  - i_rx_valid arriving in IDLE or DONE is discarded.
- RECV, on i_rx_valid:
  - shift register <= {shift[23:0], i_rx_data}, so the first byte becomes bits [31:24]
  - byte count increments
  - on the 4th byte, next state = WRITE
- WRITE (one cycle):
  - o_mem_we=1, o_mem_addr=current word address, o_mem_data=assembled word
  - o_word_count increments at the end of the cycle
  - next state:
    - DONE if word==END_WORD
    - otherwise DONE with o_full=1 if address==2**ADDR_W-1
    - otherwise RECV with the address incremented
- Byte received during WRITE: becomes byte 0 of the next word (byte count=1 on RECV entry). It is dropped if WRITE exits to DONE.
- Latency: o_mem_we rises the cycle after the clock edge that samples the 4th i_rx_valid.
- Address wrap: never wraps. The last address ends the load via o_full.
- i_start during RECV/WRITE: ignored. A partial word (1-3 bytes) stays pending indefinitely; there is no timeout.
- o_mem_data and o_mem_addr hold their last values outside WRITE. Only o_mem_we qualifies them.
- o_word_count saturates at 2**ADDR_W.

Decomposition:
- Shared package mips_pkg holds: loader state enum (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3), INSTR_W=32, BYTES_PER_WORD=4, default END_WORD (HALT encoding).
- One sub-module is natural: byte_packer (shift register + 2-bit byte counter, emits word_valid). The FSM, address counter and word counter stay in the top.

Test Plan:
- Reset, i_start with base=0, bytes AA AA BB BB CC CC DD DD FF FF FF FF -> writes addr0=AAAABBBB, addr1=CCCCDDDD, addr2=FFFFFFFF; o_done=1, o_word_count=3, o_full=0.
- i_start with base=0x10 (byte) plus 4 bytes 12 34 56 78 -> single write at word address 4, data 12345678. Base 0x13 gives the same address.
- Back-to-back i_rx_valid every cycle, including the WRITE cycle, over 8 bytes -> two writes, no byte lost, second word correct.
- ADDR_W=2, base=0, 16 non-terminator bytes -> 4 writes at addr 0..3, o_full=1, o_done=1; a 17th byte produces no write.
- Assert i_rst_n low during a WRITE cycle -> o_mem_we low immediately, all outputs 0. A new i_start then reloads from base.
- Bytes before i_start, and i_start pulses mid-load -> bytes ignored, start pulses ignored, address unchanged.
